// File: rtl/stage_ex_muldiv_if.sv
// stage_ex_muldiv_if: issue/result bundle between the EX stage and the mul/div unit
interface stage_ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  busy, done, result, rd_out
  );
  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/stage_ex_muldiv.sv
// stage_ex_muldiv: multi-cycle RV32M/RV64M multiply/divide unit for the EX stage
module stage_ex_muldiv #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  stage_ex_muldiv_if.slave bus
);
  localparam int CW = $clog2((XLEN > MUL_LATENCY ? XLEN : MUL_LATENCY) + 1);
  localparam int PW = 2 * XLEN + 2;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t          state, state_n;
  logic [2:0]      f3_r;
  logic [XLEN-1:0] a_r, b_r, rem_r, quo_r, dvs_r, result_r;
  logic [4:0]      rd_r, rd_out_r;
  logic [CW-1:0]   cnt;
  logic            q_neg, r_neg;
  logic            accept, sgn_in, neg_a, neg_b, dz, ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;
  logic [2:0]      f;
  logic [XLEN-1:0] sa, sb;
  logic signed [XLEN:0] ma, mb;
  logic signed [PW-1:0] prod;
  logic [XLEN-1:0] mul_res;
  logic [XLEN:0]   rem_sh, sub;
  logic            ge;
  logic [XLEN-1:0] rem_n, quo_n, div_res, fin_res;
  // Issue decode, special-case detection, shared multiplier and one restoring divide step
  always_comb begin
    accept   = state == IDLE && bus.start && !bus.flush;
    sgn_in   = !bus.funct3[0];
    neg_a    = sgn_in && bus.op_a[XLEN-1];
    neg_b    = sgn_in && bus.op_b[XLEN-1];
    abs_a    = neg_a ? -bus.op_a : bus.op_a;
    abs_b    = neg_b ? -bus.op_b : bus.op_b;
    dz       = bus.op_b == '0;
    ovf      = sgn_in && bus.op_a == MIN && bus.op_b == '1;
    special  = bus.funct3[2] && (dz || ovf);
    spec_res = bus.funct3[1] ? (dz ? bus.op_a : '0) : (dz ? '1 : bus.op_a);
    f        = state == IDLE ? bus.funct3 : f3_r;
    sa       = state == IDLE ? bus.op_a : a_r;
    sb       = state == IDLE ? bus.op_b : b_r;
    ma       = {f[1:0] != 2'b11 && sa[XLEN-1], sa};
    mb       = {!f[1] && sb[XLEN-1], sb};
    prod     = PW'(ma) * PW'(mb);
    mul_res  = f[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    rem_sh   = {rem_r, quo_r[XLEN-1]};
    sub      = rem_sh - {1'b0, dvs_r};
    ge       = !sub[XLEN];
    rem_n    = ge ? sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_n    = {quo_r[XLEN-2:0], ge};
    div_res  = f3_r[1] ? (r_neg ? -rem_n : rem_n) : (q_neg ? -quo_n : quo_n);
    fin_res  = state == IDLE ? (bus.funct3[2] ? spec_res : mul_res) : state == MUL ? mul_res : div_res;
  end
  // Next-state: specials and single-cycle multiplies resolve at accept, flush aborts anything in flight
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = bus.funct3[2] ? (special ? DONE : DIV) : (MUL_LATENCY == 1 ? DONE : MUL);
      MUL:     if (cnt == CW'(MUL_LATENCY - 2)) state_n = DONE;
      DIV:     if (cnt == CW'(XLEN - 1)) state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Operand latch, iteration counter, divider shift registers and committed result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      rd_r     <= '0;
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvs_r    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_r <= '0;
      rd_out_r <= '0;
    end else begin
      if (accept) begin
        f3_r  <= bus.funct3;
        a_r   <= bus.op_a;
        b_r   <= bus.op_b;
        rd_r  <= bus.rd_in;
        cnt   <= '0;
        rem_r <= '0;
        quo_r <= abs_a;
        dvs_r <= abs_b;
        q_neg <= neg_a ^ neg_b;
        r_neg <= neg_a;
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + 1'b1;
      end
      if (state == DIV) begin
        rem_r <= rem_n;
        quo_r <= quo_n;
      end
      if (state_n == DONE && state != DONE) begin
        result_r <= fin_res;
        rd_out_r <= state == IDLE ? bus.rd_in : rd_r;
      end
    end
  end
  assign bus.busy   = state != IDLE;
  assign bus.done   = state == DONE;
  assign bus.result = result_r;
  assign bus.rd_out = rd_out_r;
endmodule

// File: tb/tb_stage_ex_muldiv.sv
// tb_stage_ex_muldiv: scoreboard bench for the mul/div unit with directed vectors
module tb_stage_ex_muldiv;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
    string       name;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_done = -1;
  exp_t sb[$];
  stage_ex_muldiv_if #(.XLEN(32)) bus ();
  stage_ex_muldiv #(.XLEN(32), .MUL_LATENCY(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %0h rd %0d with nothing outstanding", bus.result, bus.rd_out);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, 64'(bus.result), 64'(e.res));
        chk({e.name, "_rd"}, 64'(bus.rd_out), 64'(e.rd));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
        last_done = cyc;
      end
    end
  end
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] res, input int lat, input bit push, input string nm, output int acc);
    int g = 0;
    @(negedge clk);
    while (bus.busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk({nm, "_issue_timeout"}, 64'(g), 64'(0));
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    acc = cyc;
    if (push) sb.push_back('{res, rd, acc + lat, nm});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op_a  = 32'hDEAD_BEEF;
    bus.op_b  = 32'h0BAD_F00D;
    bus.rd_in = 5'd30;
  endtask
  task automatic drain(input string nm);
    int g = 0;
    while ((sb.size() != 0 || bus.busy) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk({nm, "_drain_timeout"}, 64'(g), 64'(0));
  endtask
  initial begin
    int acc, acc2;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_result", 64'(bus.result), 64'(0));
    chk("reset_rd", 64'(bus.rd_out), 64'(0));
    rst = 1'b0;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2, 1, "mul_7x-3", acc);
    issue(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 2, 1, "mulh", acc);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 2, 1, "mulhsu", acc);
    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h7FFF_FFFF, 2, 1, "mulhu", acc);
    issue(3'b000, 32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0000_0000, 2, 1, "mul_wrap", acc);
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd10, 32'h0000_0001, 2, 1, "mulhu_wrap", acc);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, 33, 1, "div_-7/2", acc);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, 33, 1, "rem_-7/2", acc);
    issue(3'b101, 32'd100, 32'd7, 5'd13, 32'd14, 33, 1, "divu_100/7", acc);
    issue(3'b111, 32'd100, 32'd7, 5'd14, 32'd2, 33, 1, "remu_100/7", acc);
    issue(3'b100, 32'd20, 32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFA, 33, 1, "div_20/-3", acc);
    issue(3'b110, 32'd20, 32'hFFFF_FFFD, 5'd16, 32'd2, 33, 1, "rem_20/-3", acc);
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 33, 1, "divu_min/max", acc);
    issue(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 33, 1, "remu_min/max", acc);
    issue(3'b100, 32'd5, 32'd0, 5'd19, 32'hFFFF_FFFF, 1, 1, "div_by0", acc);
    issue(3'b110, 32'd5, 32'd0, 5'd20, 32'd5, 1, 1, "rem_by0", acc);
    issue(3'b101, 32'd9, 32'd0, 5'd21, 32'hFFFF_FFFF, 1, 1, "divu_by0", acc);
    issue(3'b111, 32'h1234_5678, 32'd0, 5'd22, 32'h1234_5678, 1, 1, "remu_by0", acc);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h8000_0000, 1, 1, "div_ovf", acc);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'd0, 1, 1, "rem_ovf", acc);
    issue(3'b000, 32'd6, 32'd7, 5'd9, 32'd42, 2, 1, "mul_6x7", acc);
    drain("basic");
    issue(3'b100, 32'd1000, 32'd3, 5'd25, 32'd0, 33, 0, "div_flushed", acc);
    while (cyc < acc + 10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'(0));
    chk("flush_result_kept", 64'(bus.result), 64'(42));
    chk("flush_rd_kept", 64'(bus.rd_out), 64'(9));
    repeat (40) @(negedge clk);
    issue(3'b101, 32'd1000, 32'd3, 5'd4, 32'd333, 33, 1, "divu_after_flush", acc);
    drain("after_flush");
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd3; bus.rd_in = 5'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_beats_start", 64'(bus.busy), 64'(0));
    repeat (5) @(negedge clk);
    issue(3'b100, 32'd100, 32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 33, 1, "div_ignore_starts", acc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_during_div", 64'(bus.busy), 64'(1));
      bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = $urandom; bus.op_b = $urandom; bus.rd_in = 5'd31;
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain("ignore_starts");
    issue(3'b000, 32'd3, 32'd5, 5'd2, 32'd15, 2, 1, "mul_flush_in_done", acc);
    while (cyc < acc + 2) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    drain("flush_in_done");
    issue(3'b000, 32'd11, 32'd11, 5'd7, 32'd121, 2, 1, "b2b_first", acc);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 2, 1, "b2b_second", acc2);
    chk("b2b_zero_bubble", 64'(acc2), 64'(last_done + 1));
    drain("b2b");
    issue(3'b100, 32'd1000, 32'd7, 5'd3, 32'd0, 33, 0, "div_reset", acc);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'(0));
    chk("async_rst_done", 64'(bus.done), 64'(0));
    chk("async_rst_result", 64'(bus.result), 64'(0));
    chk("async_rst_rd", 64'(bus.rd_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    issue(3'b000, 32'd2, 32'd3, 5'd6, 32'd6, 2, 1, "mul_after_reset", acc);
    drain("after_reset");
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end
endmodule
